// File: rtl/onn_ctrl_pkg.sv
// Shared types and sizing helpers for the ONN phase loader.
package onn_ctrl_pkg;

  localparam int unsigned ONN_ROWS = 5;
  localparam int unsigned ONN_COLS = 3;
  localparam int unsigned ONN_PW   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PAR    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } onn_state_e;

  // Width of the flattened phase bus.
  function automatic int unsigned onn_bus_w(input int unsigned rows,
                                            input int unsigned cols,
                                            input int unsigned pw);
    return rows * cols * pw;
  endfunction

  // Width needed to count 0..n accepted bits.
  function automatic int unsigned onn_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/onn_phase_loader_sipo.sv
// Shadow serial-in/parallel-out register. The first bit shifted in
// ends up at o_data[0] after N shifts.
module phase_sipo #(
  parameter int unsigned N = 60
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [0:N-1] o_data
);

  logic [0:N-1] r_data;

  // Clear wins over shift; new bits enter at the high index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= {r_data[1:N-1], i_bit};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/onn_phase_loader.sv
// ONN phase loader: serial load of the phase matrix, atomic commit onto
// the neuron phase bus, then a fixed-length run window.
// Optional build macro: ONN_LOAD_PARITY_EN adds a trailing even-parity bit.
module onn_phase_loader
  import onn_ctrl_pkg::*;
#(
  parameter int unsigned ROWS       = ONN_ROWS,
  parameter int unsigned COLS       = ONN_COLS,
  parameter int unsigned PW         = ONN_PW,
  parameter int unsigned RUN_CYCLES = 256,
  localparam int unsigned N         = onn_bus_w(ROWS, COLS, PW),
  localparam int unsigned CW        = onn_cnt_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic [0:N-1]  phi_out,
  output logic          run_en,
  output logic          busy,
  output logic          load_done,
  output logic          done,
  output logic [CW-1:0] bit_cnt,
  output logic          par_err
);

  localparam int unsigned RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  onn_state_e    r_state;
  onn_state_e    w_state_d;
  logic [0:N-1]  r_phi;
  logic [0:N-1]  w_phi_d;
  logic          r_run_en;
  logic          w_run_en_d;
  logic          r_busy;
  logic          w_busy_d;
  logic          r_load_done;
  logic          w_load_done_d;
  logic          r_done;
  logic          w_done_d;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_bit_cnt_d;
  logic [RW-1:0] r_run_cnt;
  logic [RW-1:0] w_run_cnt_d;
  logic          w_shift_en;
  logic          w_clr;
  logic [0:N-1]  w_shadow;
  logic [0:N-1]  w_full_vec;
`ifdef ONN_LOAD_PARITY_EN
  logic          r_par_err;
  logic          w_par_err_d;
  logic          r_par_acc;
  logic          w_par_acc_d;
`endif

  phase_sipo #(.N(N)) u_sipo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_en   (w_shift_en),
    .i_bit  (bit_in),
    .o_data (w_shadow)
  );

  // Matrix as it will look once the bit on bit_in has been accepted.
  assign w_full_vec = {w_shadow[1:N-1], bit_in};

  // Next-state and next-output decode; abort overrides everything.
  always_comb begin
    w_state_d     = r_state;
    w_phi_d       = r_phi;
    w_run_en_d    = 1'b0;
    w_load_done_d = 1'b0;
    w_done_d      = 1'b0;
    w_bit_cnt_d   = r_bit_cnt;
    w_run_cnt_d   = r_run_cnt;
    w_shift_en    = 1'b0;
    w_clr         = 1'b0;
`ifdef ONN_LOAD_PARITY_EN
    w_par_err_d   = r_par_err;
    w_par_acc_d   = r_par_acc;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_d   = ST_SHIFT;
          w_clr       = 1'b1;
          w_bit_cnt_d = '0;
`ifdef ONN_LOAD_PARITY_EN
          w_par_err_d = 1'b0;
          w_par_acc_d = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        if (bit_valid) begin
          w_shift_en  = 1'b1;
          w_bit_cnt_d = (r_bit_cnt == CW'(N)) ? r_bit_cnt : r_bit_cnt + CW'(1);
`ifdef ONN_LOAD_PARITY_EN
          w_par_acc_d = r_par_acc ^ bit_in;
          if (r_bit_cnt == CW'(N - 1)) begin
            w_state_d = ST_PAR;
          end
`else
          if (r_bit_cnt == CW'(N - 1)) begin
            w_state_d     = ST_COMMIT;
            w_phi_d       = w_full_vec;
            w_load_done_d = 1'b1;
          end
`endif
        end
      end
      ST_PAR: begin
`ifdef ONN_LOAD_PARITY_EN
        if (bit_valid) begin
          if ((r_par_acc ^ bit_in) == 1'b0) begin
            w_state_d     = ST_COMMIT;
            w_phi_d       = w_shadow;
            w_load_done_d = 1'b1;
          end else begin
            w_state_d   = ST_IDLE;
            w_par_err_d = 1'b1;
          end
        end
`else
        w_state_d = ST_IDLE;
`endif
      end
      ST_COMMIT: begin
        w_state_d   = ST_RUN;
        w_run_en_d  = 1'b1;
        w_run_cnt_d = '0;
      end
      ST_RUN: begin
        if (r_run_cnt == RW'(RUN_CYCLES - 1)) begin
          w_state_d = ST_DONE;
          w_done_d  = 1'b1;
        end else begin
          w_run_en_d  = 1'b1;
          w_run_cnt_d = r_run_cnt + RW'(1);
        end
      end
      ST_DONE: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      w_state_d     = ST_IDLE;
      w_phi_d       = r_phi;
      w_run_en_d    = 1'b0;
      w_load_done_d = 1'b0;
      w_done_d      = 1'b0;
      w_bit_cnt_d   = r_bit_cnt;
      w_shift_en    = 1'b0;
      w_clr         = 1'b0;
`ifdef ONN_LOAD_PARITY_EN
      w_par_err_d   = r_par_err;
      w_par_acc_d   = r_par_acc;
`endif
    end

    w_busy_d = (w_state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phi       <= '0;
      r_run_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_done      <= 1'b0;
      r_bit_cnt   <= '0;
      r_run_cnt   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_phi       <= w_phi_d;
      r_run_en    <= w_run_en_d;
      r_busy      <= w_busy_d;
      r_load_done <= w_load_done_d;
      r_done      <= w_done_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_run_cnt   <= w_run_cnt_d;
    end
  end

`ifdef ONN_LOAD_PARITY_EN
  // Running parity of accepted data bits and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
      r_par_acc <= 1'b0;
    end else begin
      r_par_err <= w_par_err_d;
      r_par_acc <= w_par_acc_d;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  assign phi_out   = r_phi;
  assign run_en    = r_run_en;
  assign busy      = r_busy;
  assign load_done = r_load_done;
  assign done      = r_done;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_onn_phase_loader.sv
// Self-checking bench for onn_phase_loader (randomized gaps and data,
// reference expectations derived from the load/run protocol).
module tb_onn_phase_loader;

  localparam int unsigned N    = 60;
  localparam int unsigned CW   = 6;
  localparam int unsigned RUNC = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          bit_in;
  logic          bit_valid;
  logic [0:N-1]  phi_out;
  logic          run_en;
  logic          busy;
  logic          load_done;
  logic          done;
  logic [CW-1:0] bit_cnt;
  logic          par_err;

  int errors = 0;
  int checks = 0;
  logic [0:N-1] exp_phi;

  onn_phase_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .phi_out   (phi_out),
    .run_en    (run_en),
    .busy      (busy),
    .load_done (load_done),
    .done      (done),
    .bit_cnt   (bit_cnt),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:N-1] rand_vec();
    logic [0:N-1] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  // One full load attempt. abort_bit / abort_run < 0 disable the aborts.
  task automatic do_load(input logic [0:N-1] data, input int gap,
                         input int abort_bit, input int abort_run, input bit bad_par);
    int acc;
    int runs;
    bit seen_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("bit_cnt_clear", bit_cnt, 0);
    check("par_err_clear", par_err, 0);
    acc = 0;
    while (acc < N) begin
      if (acc == abort_bit) begin
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0; start = 1'b0;
        check("abort_shift_busy", busy, 0);
        check("abort_shift_load_done", load_done, 0);
        check("abort_shift_phi_kept", phi_out, exp_phi);
        tick();
        check("abort_shift_idle", busy, 0);
        check("abort_shift_no_load", load_done, 0);
        return;
      end
      bit_valid = ($urandom_range(99) >= gap);
      bit_in    = bit_valid ? data[acc] : 1'($urandom);
      start     = 1'($urandom);
      tick();
      if (bit_valid) acc++;
      check("bit_cnt", bit_cnt, acc);
      if (acc < N) begin
        check("phi_hold", phi_out, exp_phi);
        check("no_early_load_done", load_done, 0);
      end
    end
    bit_valid = 1'b0;
    start     = 1'b0;
`ifdef ONN_LOAD_PARITY_EN
    check("par_phi_hold", phi_out, exp_phi);
    check("par_no_load_done", load_done, 0);
    bit_valid = 1'b1;
    bit_in    = (^data) ^ bad_par;
    tick();
    bit_valid = 1'b0;
    if (bad_par) begin
      check("par_err_set", par_err, 1);
      check("par_err_busy", busy, 0);
      check("par_err_no_load", load_done, 0);
      check("par_err_phi_kept", phi_out, exp_phi);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("par_err_no_run", run_en, 0);
        check("par_err_no_done", done, 0);
        check("par_err_sticky", par_err, 1);
      end
      return;
    end
`endif
    exp_phi = data;
    check("commit_phi", phi_out, exp_phi);
    check("load_done_pulse", load_done, 1);
    check("run_en_low_in_commit", run_en, 0);
    runs = 0;
    seen_done = 1'b0;
    for (int c = 0; c < int'(RUNC) + 8 && !seen_done; c++) begin
      start = (runs < int'(RUNC) - 4) ? 1'($urandom) : 1'b0;
      tick();
      check("load_done_single", load_done, 0);
      if (done) seen_done = 1'b1;
      else if (run_en) runs++;
      if (abort_run >= 0 && runs == abort_run && !seen_done) begin
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_run_en", run_en, 0);
        check("abort_run_busy", busy, 0);
        check("abort_run_no_done", done, 0);
        check("abort_run_phi_kept", phi_out, exp_phi);
        for (int k = 0; k < 3; k++) begin
          tick();
          check("abort_run_no_late_done", done, 0);
          check("abort_run_idle", busy, 0);
        end
        return;
      end
    end
    start = 1'b0;
    check("run_length", runs, RUNC);
    check("done_seen", seen_done, 1);
    check("run_en_off_at_done", run_en, 0);
    check("busy_at_done", busy, 1);
    tick();
    check("busy_fall", busy, 0);
    check("done_one_cycle", done, 0);
    check("phi_stable_after_run", phi_out, exp_phi);
  endtask

  initial begin
    logic [0:N-1] pat;
    logic [0:N-1] ones;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    exp_phi = '0;
    pat  = 60'hFFFF0FF0FF0FFFF;
    ones = '1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_phi", phi_out, 0);
    check("rst_run_en", run_en, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_done", done, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_par_err", par_err, 0);

    do_load(pat, 0, -1, -1, 1'b0);
    check("pat_elem4", phi_out[16 +: 4], 4'h0);
    check("pat_elem0", phi_out[0 +: 4], 4'hF);
    do_load(pat, 50, -1, -1, 1'b0);
    do_load(rand_vec(), 30, 30, -1, 1'b0);
    do_load(rand_vec(), 20, -1, -1, 1'b0);
    do_load(rand_vec(), 0, -1, 100, 1'b0);
`ifdef ONN_LOAD_PARITY_EN
    do_load(ones, 0, -1, -1, 1'b0);
    do_load(rand_vec(), 10, -1, -1, 1'b1);
`endif
    do_load(rand_vec(), 40, -1, -1, 1'b0);

    // Asynchronous reset between edges while shifting.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    exp_phi = '0;
    check("arst_phi", phi_out, 0);
    check("arst_run_en", run_en, 0);
    check("arst_busy", busy, 0);
    check("arst_load_done", load_done, 0);
    check("arst_done", done, 0);
    check("arst_bit_cnt", bit_cnt, 0);
    check("arst_par_err", par_err, 0);
    tick();
    rst = 1'b0;
    tick();
    do_load(ones ^ pat, 25, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
